// File: rtl/cpu_control_sequencer_pkg.sv
// Shared encodings for the accumulator CPU control sequencer: micro-states,
// opcodes, bus mux selects and ALU operations.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH_A  = 4'h0,
    ST_FETCH_R  = 4'h1,
    ST_DECODE   = 4'h2,
    ST_OPND_A   = 4'h3,
    ST_OPND_R   = 4'h4,
    ST_EX_ADDR  = 4'h5,
    ST_EX_READ  = 4'h6,
    ST_EX_ALU   = 4'h7,
    ST_EX_STORE = 4'h8,
    ST_EX_JUMP  = 4'h9,
    ST_HALT     = 4'hF
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] BUS_MEM = 2'd0;
  localparam logic [1:0] BUS_ACC = 2'd1;
  localparam logic [1:0] BUS_PC  = 2'd2;
  localparam logic [1:0] BUS_DR  = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  // Opcodes 0..8 and F are defined; 9..E trap into HALT.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_JC) || (op == OP_HLT);
  endfunction

  // Instructions that go through the ALU and update the flags.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_step_pulse_gen.sv
// Single-cycle rising-edge detector for the debounced panel step level.
// The history register tracks the input unconditionally so the consumer can
// freeze without a stale edge appearing later.
module step_pulse_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  // Remember last cycle's step level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step;
  end

  assign step_rise = step && !step_q;

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microcoded control sequencer for the 8-bit accumulator CPU. Walks the
// fetch / operand / execute micro-states and raises datapath strobes only in
// cycles where the sequencer actually advances.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       step,
  input  logic       manual_en,
  input  logic [3:0] ir_opcode,
  input  logic       flags_z,
  input  logic       flags_c,
  output logic [1:0] bus_sel,
  output logic       ar_load,
  output logic       ir_load,
  output logic       dr_load,
  output logic       acc_load,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       mem_cs,
  output logic       mem_we,
  output logic       flags_load,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instr_count
);

  state_t     cur_state;
  state_t     next_state;
  logic       step_rise;
  logic       advance;
  logic       set_illegal;
  logic       count_fetch;
  logic       jump_taken;

  step_pulse_gen u_step (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (step),
    .step_rise (step_rise)
  );

  assign halted  = (cur_state == ST_HALT);
  assign state   = cur_state;
  // reset_n is folded in so no strobe can leak out while reset is held.
  assign advance = reset_n && !manual_en && !halted && (run || step_rise);

  assign jump_taken = (ir_opcode == OP_JMP) ||
                      ((ir_opcode == OP_JZ) && flags_z) ||
                      ((ir_opcode == OP_JC) && flags_c);

  // Micro-state, illegal flag and fetched-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= ST_FETCH_A;
      illegal     <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      cur_state <= next_state;
      if (set_illegal) illegal <= 1'b1;
      if (count_fetch) instr_count <= instr_count + 8'd1;
    end
  end

  // Next-state and strobe decode; bus_sel/alu_op follow the state, strobes need advance.
  always_comb begin
    next_state  = cur_state;
    bus_sel     = BUS_MEM;
    alu_op      = ALU_PASS;
    ar_load     = 1'b0;
    ir_load     = 1'b0;
    dr_load     = 1'b0;
    acc_load    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    flags_load  = 1'b0;
    set_illegal = 1'b0;
    count_fetch = 1'b0;
    case (cur_state)
      ST_FETCH_A: begin
        bus_sel = BUS_PC;
        if (advance) begin
          ar_load    = 1'b1;
          next_state = ST_FETCH_R;
        end
      end
      ST_FETCH_R: begin
        bus_sel = BUS_MEM;
        if (advance) begin
          mem_cs      = 1'b1;
          ir_load     = 1'b1;
          pc_inc      = 1'b1;
          count_fetch = 1'b1;
          next_state  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (advance) begin
          if (ir_opcode == OP_NOP) begin
            next_state = ST_FETCH_A;
          end else if (ir_opcode == OP_HLT) begin
            next_state = ST_HALT;
          end else if (!is_legal(ir_opcode)) begin
            next_state  = ST_HALT;
            set_illegal = 1'b1;
          end else begin
            next_state = ST_OPND_A;
          end
        end
      end
      ST_OPND_A: begin
        bus_sel = BUS_PC;
        if (advance) begin
          ar_load    = 1'b1;
          next_state = ST_OPND_R;
        end
      end
      ST_OPND_R: begin
        bus_sel = BUS_MEM;
        if (advance) begin
          mem_cs     = 1'b1;
          dr_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = is_jump(ir_opcode) ? ST_EX_JUMP : ST_EX_ADDR;
        end
      end
      ST_EX_ADDR: begin
        bus_sel = BUS_DR;
        if (advance) begin
          ar_load    = 1'b1;
          next_state = (ir_opcode == OP_STA) ? ST_EX_STORE : ST_EX_READ;
        end
      end
      ST_EX_READ: begin
        bus_sel = BUS_MEM;
        if (advance) begin
          mem_cs     = 1'b1;
          dr_load    = 1'b1;
          next_state = ST_EX_ALU;
        end
      end
      ST_EX_ALU: begin
        case (ir_opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_PASS;
        endcase
        if (advance) begin
          acc_load   = 1'b1;
          flags_load = is_arith(ir_opcode);
          next_state = ST_FETCH_A;
        end
      end
      ST_EX_STORE: begin
        bus_sel = BUS_ACC;
        if (advance) begin
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          next_state = ST_FETCH_A;
        end
      end
      ST_EX_JUMP: begin
        bus_sel = BUS_DR;
        if (advance) begin
          pc_load    = jump_taken;
          next_state = ST_FETCH_A;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_FETCH_A;
      end
    endcase
  end

endmodule
